// File: rtl/count_seq_checker_if.sv
// Bus bundle between a count producer and the count_seq_checker monitor.
// The producer side drives samples and clear; the checker side returns
// lock status, error pulse, next expected value and statistics.
interface count_seq_checker_if #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned STAT_W = 8
);
    logic              clear;
    logic              valid;
    logic [WIDTH-1:0]  count_in;
    logic              locked;
    logic              err;
    logic [WIDTH-1:0]  expected;
    logic [STAT_W-1:0] err_count;
    logic [STAT_W-1:0] wrap_count;

    modport master (
        output clear,
        output valid,
        output count_in,
        input  locked,
        input  err,
        input  expected,
        input  err_count,
        input  wrap_count
    );

    modport slave (
        input  clear,
        input  valid,
        input  count_in,
        output locked,
        output err,
        output expected,
        output err_count,
        output wrap_count
    );
endinterface

// File: rtl/count_seq_checker.sv
// Receive-side monitor for a free-running counter bus. Checks that every
// valid sample is the previous one plus 1 (mod 2^WIDTH), acquires lock after
// LOCK_CNT consecutive good steps, pulses err on a break while locked and
// keeps saturating error / wrap statistics.
module count_seq_checker #(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned LOCK_CNT = 2,
    parameter int unsigned STAT_W   = 8
) (
    input  logic clk,
    input  logic reset,
    count_seq_checker_if.slave bus
);
    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t             r_state;
    logic [GOOD_W-1:0]  r_good;
    logic [WIDTH-1:0]   r_expected;
    logic               r_err;
    logic [STAT_W-1:0]  r_err_count;
    logic [STAT_W-1:0]  r_wrap_count;

    state_t             w_state;
    logic [GOOD_W-1:0]  w_good;
    logic [WIDTH-1:0]   w_expected;
    logic               w_err;
    logic [STAT_W-1:0]  w_err_count;
    logic [STAT_W-1:0]  w_wrap_count;

    logic               w_match;
    logic [WIDTH-1:0]   w_next_ref;
    logic [GOOD_W-1:0]  w_good_inc;

    assign w_match    = (bus.count_in == r_expected);
    assign w_next_ref = bus.count_in + WIDTH'(1);
    assign w_good_inc = r_good + GOOD_W'(1);

    // Next-state and statistics update; clear outranks valid.
    always_comb begin
        w_state      = r_state;
        w_good       = r_good;
        w_expected   = r_expected;
        w_err        = 1'b0;
        w_err_count  = r_err_count;
        w_wrap_count = r_wrap_count;

        if (bus.clear) begin
            w_state      = ST_IDLE;
            w_good       = '0;
            w_expected   = '0;
            w_err_count  = '0;
            w_wrap_count = '0;
        end else if (bus.valid) begin
            // Every accepted sample becomes the new reference, matched or not.
            w_expected = w_next_ref;
            case (r_state)
                ST_IDLE: begin
                    w_state = ST_ACQUIRE;
                    w_good  = '0;
                end
                ST_ACQUIRE: begin
                    if (w_match) begin
                        if (w_good_inc == GOOD_W'(LOCK_CNT)) begin
                            // Wrap on the locking step is deliberately not counted.
                            w_state = ST_LOCKED;
                            w_good  = '0;
                        end else begin
                            w_good = w_good_inc;
                        end
                    end else begin
                        w_good = '0;
                    end
                end
                ST_LOCKED: begin
                    if (w_match) begin
                        if (bus.count_in == '0 && r_wrap_count != '1) begin
                            w_wrap_count = r_wrap_count + STAT_W'(1);
                        end
                    end else begin
                        w_err   = 1'b1;
                        w_good  = '0;
                        w_state = ST_ACQUIRE;
                        if (r_err_count != '1) begin
                            w_err_count = r_err_count + STAT_W'(1);
                        end
                    end
                end
                default: begin
                    w_state = ST_IDLE;
                    w_good  = '0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_good       <= '0;
            r_expected   <= '0;
            r_err        <= 1'b0;
            r_err_count  <= '0;
            r_wrap_count <= '0;
        end else begin
            r_state      <= w_state;
            r_good       <= w_good;
            r_expected   <= w_expected;
            r_err        <= w_err;
            r_err_count  <= w_err_count;
            r_wrap_count <= w_wrap_count;
        end
    end

    assign bus.locked     = (r_state == ST_LOCKED);
    assign bus.err        = r_err;
    assign bus.expected   = r_expected;
    assign bus.err_count  = r_err_count;
    assign bus.wrap_count = r_wrap_count;
endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker: a vector table for the main
// sequence plus hand-written async-reset and error-saturation sequences.
module tb_count_seq_checker;
    logic clk;
    logic reset;

    count_seq_checker_if #(.WIDTH(3), .STAT_W(8)) bus ();
    count_seq_checker_if #(.WIDTH(3), .STAT_W(2)) bus2 ();

    count_seq_checker #(.WIDTH(3), .LOCK_CNT(2), .STAT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    count_seq_checker #(.WIDTH(3), .LOCK_CNT(2), .STAT_W(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned passed = 0;
    int unsigned total  = 0;

    typedef struct {
        logic        clr;
        logic        vld;
        logic [2:0]  cin;
        logic        lck;
        logic        er;
        logic [2:0]  ex;
        int unsigned ec;
        int unsigned wc;
    } vec_t;

    vec_t vecs[35];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step(input logic clr, input logic vld, input logic [2:0] cin);
        bus.clear    = clr;
        bus.valid    = vld;
        bus.count_in = cin;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic [2:0] cin);
        bus2.clear    = 1'b0;
        bus2.valid    = 1'b1;
        bus2.count_in = cin;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic lck, input logic er,
                           input logic [2:0] ex, input int unsigned ec, input int unsigned wc);
        chk({tag, ".locked"},     bus.locked,     lck);
        chk({tag, ".err"},        bus.err,        er);
        chk({tag, ".expected"},   bus.expected,   ex);
        chk({tag, ".err_count"},  bus.err_count,  ec);
        chk({tag, ".wrap_count"}, bus.wrap_count, wc);
    endtask

    initial begin
        logic [2:0] ref_exp;
        logic [2:0] m;

        // clr vld cin | locked err expected err_count wrap_count
        vecs[0]  = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd1, 0, 0};
        vecs[1]  = '{1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 3'd2, 0, 0};
        vecs[2]  = '{1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 3'd3, 0, 0};
        vecs[3]  = '{1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 3'd4, 0, 0};
        vecs[4]  = '{1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 3'd5, 0, 0};
        vecs[5]  = '{1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 3'd6, 0, 0};
        vecs[6]  = '{1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 3'd7, 0, 0};
        vecs[7]  = '{1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 3'd0, 0, 0};
        vecs[8]  = '{1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 3'd1, 0, 1};
        vecs[9]  = '{1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 3'd2, 0, 1};
        vecs[10] = '{1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 3'd3, 0, 1};
        vecs[11] = '{1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 3'd6, 1, 1};
        vecs[12] = '{1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 3'd7, 1, 1};
        vecs[13] = '{1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 3'd0, 1, 1};
        vecs[14] = '{1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 3'd0, 1, 1};
        vecs[15] = '{1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 3'd1, 1, 2};
        vecs[16] = '{1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 3'd2, 1, 2};
        vecs[17] = '{1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 3'd3, 1, 2};
        vecs[18] = '{1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 3'd3, 1, 2};
        vecs[19] = '{1'b0, 1'b0, 3'd7, 1'b1, 1'b0, 3'd3, 1, 2};
        vecs[20] = '{1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 3'd4, 1, 2};
        vecs[21] = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 3'd1, 2, 2};
        vecs[22] = '{1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 3'd2, 2, 2};
        vecs[23] = '{1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 3'd3, 2, 2};
        vecs[24] = '{1'b0, 1'b1, 3'd7, 1'b0, 1'b1, 3'd0, 3, 2};
        vecs[25] = '{1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 3'd6, 3, 2};
        vecs[26] = '{1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 3'd7, 3, 2};
        vecs[27] = '{1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 3'd0, 3, 2};
        vecs[28] = '{1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 0, 0};
        vecs[29] = '{1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 3'd7, 0, 0};
        vecs[30] = '{1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 3'd0, 0, 0};
        vecs[31] = '{1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 3'd1, 0, 0};
        vecs[32] = '{1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 3'd2, 0, 0};
        vecs[33] = '{1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 3'd6, 1, 0};
        vecs[34] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd6, 1, 0};

        reset         = 1'b0;
        bus.clear     = 1'b0;
        bus.valid     = 1'b0;
        bus.count_in  = '0;
        bus2.clear    = 1'b0;
        bus2.valid    = 1'b0;
        bus2.count_in = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk_all("reset", 1'b0, 1'b0, 3'd0, 0, 0);

        for (int i = 0; i < 35; i++) begin
            step(vecs[i].clr, vecs[i].vld, vecs[i].cin);
            chk_all($sformatf("v%0d", i), vecs[i].lck, vecs[i].er, vecs[i].ex,
                    vecs[i].ec, vecs[i].wc);
        end

        // Asynchronous reset mid-sequence: state has err_count=1, expected=6.
        #3;
        reset = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 1'b0, 3'd0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1'b0, 1'b1, 3'd4);
        chk_all("post_rst0", 1'b0, 1'b0, 3'd5, 0, 0);
        step(1'b0, 1'b1, 3'd5);
        chk_all("post_rst1", 1'b0, 1'b0, 3'd6, 0, 0);
        step(1'b0, 1'b1, 3'd6);
        chk_all("post_rst2", 1'b1, 1'b0, 3'd7, 0, 0);
        bus.valid = 1'b0;

        // Error-count saturation on the STAT_W=2 instance.
        step2(3'd0);
        step2(3'd1);
        step2(3'd2);
        chk("sat.lock0", bus2.locked, 1);
        ref_exp = 3'd3;
        for (int k = 0; k < 5; k++) begin
            m = ref_exp + 3'd4;
            step2(m);
            chk($sformatf("sat%0d.err", k), bus2.err, 1);
            chk($sformatf("sat%0d.err_count", k), bus2.err_count, (k + 1 > 3) ? 3 : k + 1);
            chk($sformatf("sat%0d.unlock", k), bus2.locked, 0);
            m = m + 3'd1;
            step2(m);
            chk($sformatf("sat%0d.err_low", k), bus2.err, 0);
            m = m + 3'd1;
            step2(m);
            chk($sformatf("sat%0d.relock", k), bus2.locked, 1);
            ref_exp = m + 3'd1;
        end
        chk("sat.wrap_count", bus2.wrap_count, 0);
        bus2.valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
